// File: rtl/pe_pkg.sv
// Shared defaults, width derivations and signed saturation helpers for the
// pipelined convolution processing element.
package pe_pkg;

  localparam int PE_DATA_WIDTH = 32;
  localparam int PE_FRAC_BITS  = 16;
  localparam int PE_KNL_W      = 5;
  localparam int PE_KNL_H      = 5;
  localparam int PE_KNL_MAXNUM = 16;

  // Wide signed carrier for the clamp helpers; any ACCW up to this fits.
  localparam int PE_SATW = 128;
  typedef logic signed [PE_SATW-1:0] pe_wide_t;

  function automatic int pe_idxw(input int maxnum);
    return $clog2(maxnum);
  endfunction

  function automatic int pe_accw(input int dw, input int fb, input int ksize);
    return 2 * dw - fb + $clog2(ksize) + 1;
  endfunction

  function automatic pe_wide_t pe_smax(input int dw);
    return (PE_SATW'(1) <<< (dw - 1)) - PE_SATW'(1);
  endfunction

  function automatic logic pe_fits(input pe_wide_t v, input int dw);
    return (v <= pe_smax(dw)) && (v >= ~pe_smax(dw));
  endfunction

  function automatic pe_wide_t pe_sat(input pe_wide_t v, input int dw);
    if (v > pe_smax(dw)) return pe_smax(dw);
    if (v < ~pe_smax(dw)) return ~pe_smax(dw);
    return v;
  endfunction

endpackage

// File: rtl/pe_dot_tree.sv
// Registered multiply/shift stage followed by an adder tree with optional
// partial-sum accumulation and saturation into the output register.
module pe_dot_tree
  import pe_pkg::*;
#(
  parameter int KNL_SIZE   = PE_KNL_W * PE_KNL_H,
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int FRAC_BITS  = PE_FRAC_BITS,
  parameter int SAT_EN     = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                vld_i,
  input  logic [KNL_SIZE-1:0][DATA_WIDTH-1:0] a_i,
  input  logic [KNL_SIZE-1:0][DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0]               psum_i,
  input  logic                                acc_en_i,
  output logic [DATA_WIDTH-1:0]               res_o,
  output logic                                vld_o,
  output logic                                ovf_o
);
  localparam int PW   = 2 * DATA_WIDTH - FRAC_BITS;
  localparam int ACCW = pe_accw(DATA_WIDTH, FRAC_BITS, KNL_SIZE);

  logic signed [PW-1:0]         prod_d  [KNL_SIZE];
  logic signed [PW-1:0]         prod_p2 [KNL_SIZE];
  logic signed [DATA_WIDTH-1:0] psum_p2;
  logic                         acc_en_p2, vld_p2;
  logic signed [ACCW-1:0]       acc;
  pe_wide_t                     acc_wide;
  logic [DATA_WIDTH-1:0]        res_d, res_q;
  logic                         vld_q;

  // S2: full-width signed products, scaled back to the fixed-point grid
  always_comb begin : mul_stage
    logic signed [2*DATA_WIDTH-1:0] full;
    full = '0;
    for (int j = 0; j < KNL_SIZE; j++) begin
      full = $signed({{DATA_WIDTH{a_i[j][DATA_WIDTH-1]}}, a_i[j]})
           * $signed({{DATA_WIDTH{b_i[j][DATA_WIDTH-1]}}, b_i[j]});
      prod_d[j] = PW'(full >>> FRAC_BITS);
    end
  end

  always_ff @(posedge clk) begin
    prod_p2   <= prod_d;
    psum_p2   <= psum_i;
    acc_en_p2 <= acc_en_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p2 <= 1'b0;
    else        vld_p2 <= vld_i;
  end

  // S3: sum, optional psum, clamp or wrap into the output register
  always_comb begin
    acc = '0;
    for (int j = 0; j < KNL_SIZE; j++) acc = acc + ACCW'(prod_p2[j]);
    if (acc_en_p2) acc = acc + ACCW'(psum_p2);
    acc_wide = PE_SATW'(acc);
    ovf_o    = vld_p2 && !pe_fits(acc_wide, DATA_WIDTH);
    res_d    = (SAT_EN != 0) ? DATA_WIDTH'(pe_sat(acc_wide, DATA_WIDTH))
                             : acc[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_p2;
      if (vld_p2) res_q <= res_d;
    end
  end

  assign res_o = res_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/pe_pipe.sv
// Pipelined convolution PE: kernel store, sliding ifmap window, snapshot stage
// and sticky status flags around a registered dot-product tree.
module pe_pipe
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int FRAC_BITS  = PE_FRAC_BITS,
  parameter int KNL_W      = PE_KNL_W,
  parameter int KNL_H      = PE_KNL_H,
  parameter int KNL_MAXNUM = PE_KNL_MAXNUM,
  parameter int SAT_EN     = 1
) (
  input  logic                          clk,
  input  logic                          srstn,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          knl_clr,
  input  logic                          ld_knl,
  input  logic                          ifmap_clr,
  input  logic                          ld_ifmap,
  input  logic                          mac_start,
  input  logic [$clog2(KNL_MAXNUM)-1:0] knl_idx,
  input  logic                          acc_en,
  input  logic [DATA_WIDTH-1:0]         psum_in,
  input  logic                          flag_clr,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          out_valid,
  output logic [$clog2(KNL_MAXNUM):0]   knl_cnt,
  output logic                          ifmap_full,
  output logic                          err,
  output logic                          ovf
);
  localparam int KNL_SIZE = KNL_W * KNL_H;
  localparam int IDXW     = pe_idxw(KNL_MAXNUM);
  localparam int CNTW     = IDXW + 1;
  localparam int KTOT     = KNL_MAXNUM * KNL_SIZE;
  localparam int KAW      = $clog2(KTOT);
  localparam int CW       = $clog2(KNL_SIZE);
  localparam int FW       = $clog2(KNL_SIZE + 1);

  logic [KAW-1:0]  wptr_q, wptr_d;
  logic [CW-1:0]   wcol_q, wcol_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            err_q, err_d, ovf_q, ovf_d;
  logic            last_word, err_hit, ovf_hit;
  logic [KAW-1:0]  kbase;

  logic [DATA_WIDTH-1:0] knl_mem [KTOT];
  logic [DATA_WIDTH-1:0] win_q   [KNL_SIZE];

  logic [KNL_SIZE-1:0][DATA_WIDTH-1:0] knl_p1, win_p1;
  logic [DATA_WIDTH-1:0]               psum_p1;
  logic                                acc_en_p1, vld_p1;

  always_comb begin
    last_word = (wcol_q == CW'(KNL_SIZE - 1));
    wptr_d    = wptr_q;
    wcol_d    = wcol_q;
    cnt_d     = cnt_q;
    if (knl_clr) begin
      wptr_d = '0;
      wcol_d = '0;
      cnt_d  = '0;
    end else if (ld_knl) begin
      wptr_d = (wptr_q == KAW'(KTOT - 1)) ? '0 : wptr_q + KAW'(1);
      wcol_d = last_word ? '0 : wcol_q + CW'(1);
      if (last_word && cnt_q != CNTW'(KNL_MAXNUM)) cnt_d = cnt_q + CNTW'(1);
    end

    fill_d = fill_q;
    if (ifmap_clr)                                   fill_d = '0;
    else if (ld_ifmap && fill_q != FW'(KNL_SIZE))    fill_d = fill_q + FW'(1);

    // Flags are judged on the state seen by this start; the op runs regardless.
    err_hit = mac_start && (({1'b0, knl_idx} >= cnt_q) || (fill_q != FW'(KNL_SIZE)));
    err_d   = err_hit || (err_q && !flag_clr);
    ovf_d   = ovf_hit || (ovf_q && !flag_clr);
    kbase   = KAW'(knl_idx) * KAW'(KNL_SIZE);
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      wptr_q <= '0;
      wcol_q <= '0;
      cnt_q  <= '0;
      fill_q <= '0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      wcol_q <= wcol_d;
      cnt_q  <= cnt_d;
      fill_q <= fill_d;
      err_q  <= err_d;
      ovf_q  <= ovf_d;
      vld_p1 <= mac_start;
    end
  end

  // Weight and pixel storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (ld_knl && !knl_clr) knl_mem[wptr_q] <= data_in;
    if (ld_ifmap) begin
      for (int i = 0; i < KNL_SIZE - 1; i++) win_q[i] <= win_q[i + 1];
      win_q[KNL_SIZE-1] <= data_in;
    end
  end

  // S1: snapshot kernel and window, reordering pixels to row-major pairing
  always_ff @(posedge clk) begin
    if (mac_start) begin
      psum_p1   <= psum_in;
      acc_en_p1 <= acc_en;
      for (int r = 0; r < KNL_H; r++) begin
        for (int c = 0; c < KNL_W; c++) begin
          knl_p1[r*KNL_W + c] <= knl_mem[kbase + KAW'(r*KNL_W + c)];
          win_p1[r*KNL_W + c] <= win_q[c*KNL_H + r];
        end
      end
    end
  end

  pe_dot_tree #(
    .KNL_SIZE   (KNL_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .SAT_EN     (SAT_EN)
  ) u_tree (
    .clk      (clk),
    .rst_n    (srstn),
    .vld_i    (vld_p1),
    .a_i      (knl_p1),
    .b_i      (win_p1),
    .psum_i   (psum_p1),
    .acc_en_i (acc_en_p1),
    .res_o    (data_out),
    .vld_o    (out_valid),
    .ovf_o    (ovf_hit)
  );

  assign knl_cnt    = cnt_q;
  assign ifmap_full = (fill_q == FW'(KNL_SIZE));
  assign err        = err_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_pe_pipe.sv
// Directed plus randomized bench for pe_pipe against a cycle-level behavioural model.
module tb_pe_pipe;
  localparam int KW = 5, KH = 5, KS = 25, KMAX = 16;
  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -SMAX - 1;

  logic        clk = 1'b0;
  logic        srstn = 1'b1;
  logic [31:0] data_in = '0, psum_in = '0;
  logic        knl_clr = 0, ld_knl = 0, ifmap_clr = 0, ld_ifmap = 0;
  logic        mac_start = 0, acc_en = 0, flag_clr = 0;
  logic [3:0]  knl_idx = '0;
  logic [31:0] data_out;
  logic        out_valid, ifmap_full, err, ovf;
  logic [4:0]  knl_cnt;

  always #5 clk = ~clk;

  pe_pipe dut (
    .clk(clk), .srstn(srstn), .data_in(data_in), .knl_clr(knl_clr), .ld_knl(ld_knl),
    .ifmap_clr(ifmap_clr), .ld_ifmap(ld_ifmap), .mac_start(mac_start), .knl_idx(knl_idx),
    .acc_en(acc_en), .psum_in(psum_in), .flag_clr(flag_clr), .data_out(data_out),
    .out_valid(out_valid), .knl_cnt(knl_cnt), .ifmap_full(ifmap_full), .err(err), .ovf(ovf)
  );

  typedef struct { int due; logic [31:0] data; bit ovf; } res_t;

  int          total = 0, bad = 0, cyc = 0;
  logic [31:0] m_knl [KMAX][KS];
  logic [31:0] m_win [$];
  res_t        pend  [$];
  int          m_wptr = 0, m_cnt = 0, m_fill = 0;
  bit          m_err = 0, m_ovf = 0, exp_vld = 0;
  logic [31:0] last_out = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model_mac(input int idx, input bit acc, input logic [31:0] ps, input int due);
    longint s = 0;
    res_t   r;
    for (int rr = 0; rr < KH; rr++)
      for (int cc = 0; cc < KW; cc++)
        s += (longint'($signed(m_knl[idx][rr*KW + cc])) * longint'($signed(m_win[cc*KH + rr]))) >>> 16;
    if (acc) s += longint'($signed(ps));
    r.due = due;
    r.ovf = (s > SMAX) || (s < SMIN);
    if (s > SMAX)      r.data = 32'h7FFFFFFF;
    else if (s < SMIN) r.data = 32'h80000000;
    else               r.data = s[31:0];
    return r;
  endfunction

  task automatic check_state();
    chk("out_valid",  64'(out_valid),  64'(exp_vld));
    chk("data_out",   64'(data_out),   64'(last_out));
    chk("err",        64'(err),        64'(m_err));
    chk("ovf",        64'(ovf),        64'(m_ovf));
    chk("knl_cnt",    64'(knl_cnt),    64'(m_cnt));
    chk("ifmap_full", 64'(ifmap_full), 64'(m_fill == KS));
  endtask

  // Advance one clock: update the model with the inputs the DUT samples, then compare.
  task automatic tick();
    int nc = cyc + 1;
    bit ovf_set = 0, err_set = 0;
    exp_vld = 0;
    if (srstn) begin
      if (pend.size() > 0 && pend[0].due == nc) begin
        exp_vld  = 1;
        last_out = pend[0].data;
        ovf_set  = pend[0].ovf;
        void'(pend.pop_front());
      end
      if (mac_start) begin
        err_set = (int'(knl_idx) >= m_cnt) || (m_fill != KS);
        pend.push_back(model_mac(int'(knl_idx), acc_en, psum_in, nc + 2));
      end
      m_err = err_set || (m_err && !flag_clr);
      m_ovf = ovf_set || (m_ovf && !flag_clr);
      if (knl_clr) begin
        m_wptr = 0;
        m_cnt  = 0;
      end else if (ld_knl) begin
        m_knl[m_wptr / KS][m_wptr % KS] = data_in;
        if (m_wptr % KS == KS - 1 && m_cnt < KMAX) m_cnt++;
        m_wptr = (m_wptr + 1) % (KMAX * KS);
      end
      if (ld_ifmap) begin
        m_win.push_back(data_in);
        if (m_win.size() > KS) void'(m_win.pop_front());
      end
      if (ifmap_clr) m_fill = 0;
      else if (ld_ifmap && m_fill < KS) m_fill++;
    end
    @(posedge clk);
    #1;
    cyc = nc;
    check_state();
  endtask

  task automatic ld_k(input logic [31:0] v);
    data_in = v; ld_knl = 1; tick(); ld_knl = 0;
  endtask

  task automatic ld_i(input logic [31:0] v);
    data_in = v; ld_ifmap = 1; tick(); ld_ifmap = 0;
  endtask

  task automatic start(input int idx, input bit acc, input logic [31:0] ps);
    mac_start = 1; knl_idx = 4'(idx); acc_en = acc; psum_in = ps;
    tick();
    mac_start = 0; acc_en = 0;
  endtask

  task automatic pulse_flag_clr();
    flag_clr = 1; tick(); flag_clr = 0;
  endtask

  task automatic do_reset();
    srstn = 0;
    #1;
    pend.delete();
    m_wptr = 0; m_cnt = 0; m_fill = 0; m_err = 0; m_ovf = 0;
    last_out = '0; exp_vld = 0;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_data_out",  64'(data_out),  64'(0));
    chk("rst_knl_cnt",   64'(knl_cnt),   64'(0));
    chk("rst_flags",     64'({err, ovf, ifmap_full}), 64'(0));
    tick();
    tick();
    srstn = 1;
  endtask

  initial begin
    #2;
    do_reset();

    // Fill every kernel slot so later out-of-range starts read defined weights.
    for (int i = 0; i < KMAX * KS; i++) ld_k($urandom());
    chk("knl_cnt_sat", 64'(knl_cnt), 64'(KMAX));
    knl_clr = 1; tick(); knl_clr = 0;

    for (int i = 0; i < KS; i++) ld_k(32'h0001_0000);
    for (int i = 0; i < KS; i++) ld_i(32'h0002_0000);
    start(0, 0, '0);
    tick(); tick();
    chk("tp_plain_valid", 64'(out_valid), 64'(1));
    chk("tp_plain_data",  64'(data_out),  64'(32'h0032_0000));
    chk("tp_plain_err",   64'({err, ovf}), 64'(0));

    start(0, 1, 32'h0001_0000);
    tick(); tick();
    chk("tp_acc_data", 64'(data_out), 64'(32'h0033_0000));

    for (int i = 0; i < KS; i++) ld_k(32'hFFFF_0000);
    start(0, 0, '0);
    start(1, 0, '0);
    tick();
    chk("tp_b2b_first",  64'({out_valid, data_out}), {31'd0, 1'b1, 32'h0032_0000});
    tick();
    chk("tp_b2b_second", 64'({out_valid, data_out}), {31'd0, 1'b1, 32'hFFCE_0000});
    tick();
    chk("tp_b2b_gap", 64'(out_valid), 64'(0));

    start(3, 0, '0);
    chk("tp_err_idx", 64'(err), 64'(1));
    ifmap_clr = 1; tick(); ifmap_clr = 0;
    start(0, 0, '0);
    chk("tp_err_stays", 64'(err), 64'(1));
    repeat (3) tick();
    pulse_flag_clr();
    chk("tp_err_clr", 64'(err), 64'(0));

    knl_clr = 1; tick(); knl_clr = 0;
    for (int i = 0; i < KS; i++) ld_k(32'h7FFF_0000);
    for (int i = 0; i < KS; i++) ld_i(32'h7FFF_0000);
    start(0, 0, '0);
    tick(); tick();
    chk("tp_sat_data", 64'(data_out), 64'(32'h7FFF_FFFF));
    chk("tp_sat_ovf",  64'(ovf),      64'(1));
    pulse_flag_clr();
    chk("tp_sat_ovf_clr", 64'(ovf), 64'(0));

    for (int i = 0; i < 300; i++) begin
      data_in   = ($urandom_range(0, 7) == 0) ? $urandom()
                                              : 32'($urandom_range(0, 32'h3FFFF)) - 32'h2_0000;
      ld_knl    = ($urandom_range(0, 3) == 0);
      knl_clr   = ($urandom_range(0, 40) == 0);
      ld_ifmap  = ($urandom_range(0, 2) == 0);
      ifmap_clr = ($urandom_range(0, 40) == 0);
      mac_start = 1'($urandom_range(0, 1));
      knl_idx   = 4'($urandom_range(0, 15));
      acc_en    = 1'($urandom_range(0, 1));
      psum_in   = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 32'hFFFFF));
      flag_clr  = ($urandom_range(0, 20) == 0);
      tick();
    end
    {ld_knl, knl_clr, ld_ifmap, ifmap_clr, mac_start, acc_en, flag_clr} = '0;
    repeat (4) tick();

    for (int i = 0; i < KS; i++) ld_i(32'h0001_0000);
    start(0, 0, '0);
    start(0, 0, '0);
    do_reset();
    repeat (5) tick();
    chk("post_rst_knl_cnt", 64'(knl_cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
